fix_point_mult_pipe: RTL

Pipelined, parametrised signed fixed-point multiplier with valid/ready flow control, selectable rounding, saturation with an overflow flag, and a sideband tag carried alongside each operand pair. It replaces the combinational Q-format multiply in the billiard physics datapath, where it computes velocity, friction and collision products. It sustains one multiply per clock and stalls cleanly under downstream backpressure.

---
 rtl/fix_point_pkg.sv | 22 ++
 rtl/fix_point_round_sat.sv | 41 ++++
 rtl/fix_point_mult_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/fix_point_pkg.sv
// Shared Q-format constants and record types for the fixed-point datapath blocks
// (multiplier, and the divider/MAC that reuse the same rounding stage).
package fix_point_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_FRAC_WIDTH = 30;
   localparam int DEF_TAG_WIDTH  = 8;

   localparam logic signed [DEF_WIDTH-1:0] ONE =
      {{(DEF_WIDTH-1){1'b0}}, 1'b1} << DEF_FRAC_WIDTH;
   localparam logic signed [DEF_WIDTH-1:0] MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
   localparam logic signed [DEF_WIDTH-1:0] MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

   // One pipeline slot in the default Q format.
   typedef struct packed {
      logic                             valid;
      logic signed [DEF_WIDTH-1:0]      data;
      logic                             ovf;
      logic        [DEF_TAG_WIDTH-1:0]  tag;
   } stage_rec_t;

endpackage

// File: rtl/fix_point_round_sat.sv
// Combinational rescale of a full 2*WIDTH product back to Q format:
// optional half-up rounding, arithmetic shift, then saturate or wrap.
module fix_point_round_sat
   import fix_point_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
   parameter int ROUND      = 1,
   parameter int SATURATE   = 1
) (
   input  logic signed [2*WIDTH-1:0] prod,
   output logic signed [WIDTH-1:0]   xy,
   output logic                      ovf
);

   localparam int PW = 2*WIDTH;
   localparam int SW = PW - FRAC_WIDTH + 1;

   localparam logic signed [PW:0] RND =
      (ROUND != 0) ? ({{PW{1'b0}}, 1'b1} << (FRAC_WIDTH-1)) : '0;
   localparam logic signed [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [SW-1:0]     scaled;
   logic        [SW-WIDTH:0] head;

   // One guard bit above the product keeps the rounding carry.
   assign scaled = SW'(($signed({prod[PW-1], prod}) + RND) >>> FRAC_WIDTH);

   // In range exactly when every bit from the result sign upward agrees.
   assign head = scaled[SW-1:WIDTH-1];
   assign ovf  = !((&head) || !(|head));

   always_comb begin
      xy = scaled[WIDTH-1:0];
      if (ovf && (SATURATE != 0)) begin
         xy = scaled[SW-1] ? Q_MIN : Q_MAX;
      end
   end

endmodule

// File: rtl/fix_point_mult_pipe.sv
// Pipelined signed Q-format multiplier with valid/ready flow control and a tag
// travelling alongside each operand pair; STAGES registers in total.
module fix_point_mult_pipe
   import fix_point_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
   parameter int STAGES     = 2,
   parameter int ROUND      = 1,
   parameter int SATURATE   = 1,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH-1:0]     in_x,
   input  logic signed [WIDTH-1:0]     in_y,
   input  logic        [TAG_WIDTH-1:0] in_tag,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [WIDTH-1:0]     out_xy,
   output logic                        out_ovf,
   output logic        [TAG_WIDTH-1:0] out_tag
);

   localparam int PW = 2*WIDTH;

   typedef struct packed {
      logic                        valid;
      logic signed [PW-1:0]        prod;
      logic        [TAG_WIDTH-1:0] tag;
   } prod_stage_t;

   logic                        stall;
   logic                        advance;
   logic                        accept;
   logic                        rs_valid;
   logic signed [PW-1:0]        rs_prod;
   logic        [TAG_WIDTH-1:0] rs_tag;
   logic signed [WIDTH-1:0]     rs_xy;
   logic                        rs_ovf;

   // NOTE: in_ready is combinational from out_ready so the pipe restarts in
   // the same cycle the consumer frees the output register.
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign advance  = !stall;
   assign accept   = in_valid && in_ready;

   generate
      if (STAGES == 1) begin : g_single
         assign rs_valid = accept;
         assign rs_prod  = PW'(in_x) * PW'(in_y);
         assign rs_tag   = in_tag;
      end else begin : g_multi
         prod_stage_t stage_q [STAGES-1];

         // NOTE: only the valid bits are reset; payload is always qualified
         // by valid, so clearing it would just add reset fan-out.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < STAGES-1; i++) begin
                  stage_q[i].valid <= 1'b0;
               end
            end else if (advance) begin
               stage_q[0].valid <= accept;
               stage_q[0].prod  <= PW'(in_x) * PW'(in_y);
               stage_q[0].tag   <= in_tag;
               for (int i = 1; i < STAGES-1; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign rs_valid = stage_q[STAGES-2].valid;
         assign rs_prod  = stage_q[STAGES-2].prod;
         assign rs_tag   = stage_q[STAGES-2].tag;
      end
   endgenerate

   fix_point_round_sat #(
      .WIDTH      (WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .ROUND      (ROUND),
      .SATURATE   (SATURATE)
   ) u_round_sat (
      .prod (rs_prod),
      .xy   (rs_xy),
      .ovf  (rs_ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_xy    <= '0;
         out_ovf   <= 1'b0;
         out_tag   <= '0;
      end else if (advance) begin
         out_valid <= rs_valid;
         if (rs_valid) begin
            out_xy  <= rs_xy;
            out_ovf <= rs_ovf;
            out_tag <= rs_tag;
         end
      end
   end

endmodule
